// File: rtl/vote_display_controller.sv
// vote_display_controller: picks one of four binary vote totals, saturates it
// to 9999, converts it to four BCD digits with a sequential double-dabble
// (one iteration per clock) and holds the result for the seven-segment driver.
// The displayed candidate advances on a button pulse or after a dwell time in
// auto-rotate mode, and the same candidate is re-converted when its count moves.
//
// Handshake/timing contract: busy is high exactly while a conversion runs
// (LOAD + 14 SHIFT cycles); the digit outputs change only on the edge that
// ends the last SHIFT cycle, so they never show partial BCD values.
module vote_display_controller #(
  parameter int DWELL_CYCLES = 200000000,
  parameter int CNT_W        = 14
) (
  input  logic             clk_100MHz,
  input  logic             reset,
  input  logic [CNT_W-1:0] count0,
  input  logic [CNT_W-1:0] count1,
  input  logic [CNT_W-1:0] count2,
  input  logic [CNT_W-1:0] count3,
  input  logic             next_btn,
  input  logic             auto_en,
  output logic [3:0]       ones,
  output logic [3:0]       tens,
  output logic [3:0]       hundreds,
  output logic [3:0]       thousands,
  output logic [1:0]       cand_sel,
  output logic             busy,
  output logic [1:0]       state_dbg
);

  localparam int DW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, HOLD} state_t;

  state_t         state;
  logic [13:0]    snap;
  logic [13:0]    bin_sr;
  logic [15:0]    bcd_sr;
  logic [3:0]     iter;
  logic [DW-1:0]  dwell;
  logic           pending;

  logic [CNT_W-1:0] sel_count;
  logic [13:0]      sel_sat;
  logic [15:0]      bcd_adj;
  logic [15:0]      bcd_next;
  logic             expire;
  logic             advance;
  logic             stale;

  assign state_dbg = state;

  // Select the count of the candidate currently shown.
  always_comb begin
    sel_count = count0;
    case (cand_sel)
      2'd0: sel_count = count0;
      2'd1: sel_count = count1;
      2'd2: sel_count = count2;
      2'd3: sel_count = count3;
      default: sel_count = count0;
    endcase
  end

  // Clamp the selected count to the four-digit display range.
  always_comb begin
    if (sel_count > CNT_W'(9999)) sel_sat = 14'd9999;
    else                          sel_sat = sel_count[13:0];
  end

  // One double-dabble step: add 3 to nibbles >= 5, then shift in the binary MSB.
  always_comb begin
    bcd_adj = bcd_sr;
    for (int i = 0; i < 4; i++) begin
      if (bcd_sr[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_sr[4*i +: 4] + 4'd3;
    end
    bcd_next = 16'({bcd_adj, bin_sr[13]});
  end

  // Decisions taken while holding a finished display.
  always_comb begin
    expire  = auto_en && (dwell == DWELL_LAST);
    advance = next_btn || pending || expire;
    stale   = (sel_sat != snap);
  end

  // Control FSM with registered outputs.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cand_sel  <= 2'd0;
      busy      <= 1'b0;
      ones      <= 4'd0;
      tens      <= 4'd0;
      hundreds  <= 4'd0;
      thousands <= 4'd0;
      snap      <= 14'd0;
      bin_sr    <= 14'd0;
      bcd_sr    <= 16'd0;
      iter      <= 4'd0;
      dwell     <= '0;
      pending   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state <= LOAD;
          busy  <= 1'b1;
        end
        LOAD: begin
          snap   <= sel_sat;
          bin_sr <= sel_sat;
          bcd_sr <= 16'd0;
          iter   <= 4'd0;
          state  <= SHIFT;
          if (next_btn) pending <= 1'b1;
        end
        SHIFT: begin
          if (next_btn) pending <= 1'b1;
          bcd_sr <= bcd_next;
          bin_sr <= {bin_sr[12:0], 1'b0};
          iter   <= iter + 4'd1;
          if (iter == 4'd13) begin
            {thousands, hundreds, tens, ones} <= bcd_next;
            state <= HOLD;
            busy  <= 1'b0;
          end
        end
        HOLD: begin
          if (advance) begin
            // Button, pending request and dwell expiry together still move one step.
            cand_sel <= cand_sel + 2'd1;
            dwell    <= '0;
            pending  <= 1'b0;
            state    <= LOAD;
            busy     <= 1'b1;
          end else if (stale) begin
            state <= LOAD;
            busy  <= 1'b1;
          end else if (auto_en) begin
            dwell <= dwell + 1'b1;
          end else begin
            dwell <= '0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vote_display_controller.sv
// Bench for vote_display_controller: directed scenarios with literal digit
// expectations, then randomized buttons/auto mode/count changes/resets, all
// compared each cycle with a behavioural model built on decimal arithmetic.
module tb_vote_display_controller;

  localparam int DWELL = 50;

  // clock / reset
  logic clk_100MHz;
  logic reset;
  initial begin
    clk_100MHz = 1'b0;
    forever #5 clk_100MHz = ~clk_100MHz;
  end

  logic [13:0] cnt [4];
  logic        next_btn;
  logic        auto_en;
  logic [3:0]  ones, tens, hundreds, thousands;
  logic [1:0]  cand_sel;
  logic        busy;
  logic [1:0]  state_dbg;

  vote_display_controller #(.DWELL_CYCLES(DWELL), .CNT_W(14)) dut (
    .clk_100MHz (clk_100MHz),
    .reset      (reset),
    .count0     (cnt[0]),
    .count1     (cnt[1]),
    .count2     (cnt[2]),
    .count3     (cnt[3]),
    .next_btn   (next_btn),
    .auto_en    (auto_en),
    .ones       (ones),
    .tens       (tens),
    .hundreds   (hundreds),
    .thousands  (thousands),
    .cand_sel   (cand_sel),
    .busy       (busy),
    .state_dbg  (state_dbg)
  );

  int n_vec = 0;
  int n_err = 0;

  // reference model: phase 0 = waiting after reset, 1 = converting, 2 = showing
  int m_phase = 0;
  int m_k     = 0;
  int m_cand  = 0;
  int m_snap  = 0;
  int m_shown = 0;
  int m_dwell = 0;
  bit m_pend  = 0;

  function automatic int sat(input int v);
    return (v > 9999) ? 9999 : v;
  endfunction

  function automatic logic [15:0] digits_of(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  initial begin
    forever begin
      @(posedge clk_100MHz or posedge reset);
      if (reset) begin
        m_phase = 0; m_k = 0; m_cand = 0; m_snap = 0;
        m_shown = 0; m_dwell = 0; m_pend = 0;
      end else begin
        case (m_phase)
          0: begin
            m_phase = 1;
            m_k = 0;
          end
          1: begin
            if (next_btn) m_pend = 1;
            if (m_k == 0) m_snap = sat(int'(cnt[m_cand]));
            if (m_k == 14) begin
              m_shown = m_snap;
              m_phase = 2;
            end else begin
              m_k++;
            end
          end
          default: begin
            if (next_btn || m_pend || (auto_en && m_dwell == DWELL - 1)) begin
              m_cand  = (m_cand + 1) % 4;
              m_dwell = 0;
              m_pend  = 0;
              m_phase = 1;
              m_k     = 0;
            end else if (sat(int'(cnt[m_cand])) != m_snap) begin
              m_phase = 1;
              m_k     = 0;
            end else begin
              m_dwell = auto_en ? m_dwell + 1 : 0;
            end
          end
        endcase
      end
    end
  end

  // scoreboard: every cycle, shortly after the active edge
  initial begin
    logic [15:0] exp_dig;
    forever begin
      @(posedge clk_100MHz);
      #1;
      exp_dig = digits_of(m_shown);
      n_vec++;
      if (cand_sel !== 2'(m_cand) || busy !== (m_phase == 1) ||
          {thousands, hundreds, tens, ones} !== exp_dig) begin
        n_err++;
        $display("FAIL cycle_cmp t=%0t: got cand_sel=%0d busy=%0d digits=%h, want cand_sel=%0d busy=%0d digits=%h",
                 $time, cand_sel, busy, {thousands, hundreds, tens, ones},
                 m_cand, (m_phase == 1), exp_dig);
      end
    end
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(negedge clk_100MHz);
  endtask

  task automatic pulse_next();
    next_btn = 1'b1;
    @(negedge clk_100MHz);
    next_btn = 1'b0;
  endtask

  task automatic check_lit(input string name, input int act, input int exp_v);
    n_vec++;
    if (act != exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp_v);
    end
  endtask

  task automatic check_disp(input string name, input int exp_cand, input int exp_digits);
    check_lit({name, "_cand"}, int'(cand_sel), exp_cand);
    check_lit({name, "_digits"}, int'({thousands, hundreds, tens, ones}), exp_digits);
  endtask

  // stimulus
  initial begin
    reset = 1'b1;
    next_btn = 1'b0;
    auto_en = 1'b0;
    cnt[0] = 14'd1234; cnt[1] = 14'd16383; cnt[2] = 14'd41; cnt[3] = 14'd0;
    tick(3);
    check_lit("reset_busy", int'(busy), 0);
    check_disp("reset", 0, 'h0000);

    // first conversion after reset release: 1234
    reset = 1'b0;
    tick(1);
    check_lit("busy_after_release", int'(busy), 1);
    tick(14);
    check_lit("busy_last_shift", int'(busy), 1);
    tick(1);
    check_lit("busy_done", int'(busy), 0);
    check_disp("first_conv", 0, 'h1234);

    // button in HOLD, saturated count
    pulse_next();
    tick(16);
    check_disp("saturate", 1, 'h9999);

    // two presses during one conversion give one extra step
    pulse_next();
    tick(3);
    pulse_next();
    tick(2);
    pulse_next();
    tick(40);
    check_disp("pending_one_deep", 3, 'h0000);

    // walk to candidate 2, then refresh on count change
    pulse_next(); tick(20);
    pulse_next(); tick(20);
    pulse_next(); tick(20);
    check_disp("cand2", 2, 'h0041);
    cnt[2] = 14'd42;
    tick(20);
    check_disp("refresh", 2, 'h0042);

    // reset in the middle of a conversion
    cnt[2] = 14'd9000;
    tick(6);
    check_lit("mid_shift_busy", int'(busy), 1);
    reset = 1'b1;
    #1;
    check_lit("abort_busy", int'(busy), 0);
    check_disp("abort", 0, 'h0000);
    @(negedge clk_100MHz);
    tick(2);

    // auto-rotate through 0 / 7 / 80 / 905
    cnt[0] = 14'd0; cnt[1] = 14'd7; cnt[2] = 14'd80; cnt[3] = 14'd905;
    auto_en = 1'b1;
    reset = 1'b0;
    tick(16);
    check_disp("auto0", 0, 'h0000);
    tick(65);
    check_disp("auto1", 1, 'h0007);
    tick(65);
    check_disp("auto2", 2, 'h0080);
    tick(65);
    check_disp("auto3", 3, 'h0905);

    // button coinciding with dwell expiry advances only once (3 -> 0)
    tick(49);
    pulse_next();
    check_lit("coincide_cand", int'(cand_sel), 0);
    tick(15);
    check_disp("coincide", 0, 'h0000);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      next_btn = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 99) == 0) auto_en = ~auto_en;
      if ($urandom_range(0, 39) == 0) begin
        if ($urandom_range(0, 1) == 0) cnt[$urandom_range(0, 3)] = 14'($urandom_range(0, 16383));
        else                           cnt[$urandom_range(0, 3)] = 14'($urandom_range(9990, 10010));
      end
      reset = ($urandom_range(0, 499) == 0);
      tick(1);
    end
    reset = 1'b0;
    next_btn = 1'b0;
    tick(40);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
